logic_eval_pipe: RTL and testbench
==================================

LOGIC_EVAL_PIPE -- requirements
Module: logic_eval_pipe

Interface
REQ-001 Parameter NPI, default 6: number of primary inputs, 2..32.
REQ-002 Parameter NPO, default 6: number of primary outputs, 1..16.
REQ-003 Parameter DEPTH, default 2: pipeline register stages, 1..4.
REQ-004 Parameter SIG_W, default 16: signature width, 8..32.
REQ-005 Parameter POLY, default 16'h1021: signature feedback polynomial, low SIG_W bits used.
REQ-006 Reset and clock: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 cfg_we  in  1  config write strobe.
REQ-010 cfg_idx  in  clog2(NPO), min 1  output index to configure.
REQ-011 cfg_mask_a  in  NPI  input-select mask, term A.
REQ-012 cfg_mask_b  in  NPI  input-select mask, term B.
REQ-013 cfg_op  in  3  [0] op_a, [1] op_b, [2] op_out; 0=AND, 1=OR.
REQ-014 in_valid  in  1  / in_ready  out  1  input handshake.
REQ-015 pi  in  NPI  input vector.
REQ-016 out_valid  out  1  / out_ready  in  1  output handshake.
REQ-017 po  out  NPO  evaluated output vector.
REQ-018 sig  out  SIG_W  running output signature.
REQ-019 sig_clr  in  1  clears sig and txn_cnt.
REQ-020 txn_cnt  out  16  count of output handshakes.

Function
REQ-021 Term A for output k: op_a=AND -> AND over pi bits selected by mask_a[k] (1 if mask empty); op_a=OR -> OR over selected bits (0 if mask empty); term B identical using mask_b[k], op_b.
REQ-022 po[k] = A&B when op_out=0, A|B when op_out=1.
REQ-023 Evaluation combinational from pi and current config; result captured in stage 1 on input handshake (in_valid & in_ready).
REQ-024 Stages 2..DEPTH: plain registers with per-stage valid; po/out_valid driven from stage DEPTH.
REQ-025 Bubble-collapsing: stage i loads when empty or when stage i+1 loads this cycle; stage DEPTH drains on out_valid & out_ready; in_ready = stage-1 load condition.
REQ-026 No stalls: latency exactly DEPTH cycles, throughput one vector per cycle.
REQ-027 While out_valid=1 and out_ready=0, po SHALL hold stable; no vector lost or duplicated.
REQ-028 cfg_we=1 at edge t updates entry cfg_idx; vectors accepted at edge t use the old config, vectors accepted at t+1 onward use the new.
REQ-029 cfg_we with cfg_idx >= NPO SHALL be ignored.
REQ-030 On each output handshake: sig <= ({sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ zero-extended po; txn_cnt <= txn_cnt+1, wrapping 16'hFFFF -> 0.
REQ-031 sig_clr=1 SHALL set sig=0 and txn_cnt=0 and take priority over a simultaneous handshake (that vector not folded, not counted); the handshake itself still completes.

Reset
REQ-032 rst SHALL clear all stage valids, out_valid=0, po=0, sig=0, txn_cnt=0.
REQ-033 rst SHALL set every config entry to mask_a=0, mask_b=0, cfg_op=3'b000 (each po evaluates to 1).
REQ-034 in_ready SHALL be 0 during the rst cycle and 1 in the cycle after.
REQ-035 rst mid-operation SHALL discard all in-flight vectors; rst overrides cfg_we and sig_clr in the same cycle.

Verification (NPI=6, NPO=6, DEPTH=2)
REQ-036 Reset, then pi=6'h00 valid, no config -> po=6'h3F two cycles later, sig=16'h003F after handshake.
REQ-037 Config k0 mask_a=6'h03 op=000; k1 mask_a=6'h03 op=001 (mask_b=0, op_b=AND so B=1); k4 mask_a=6'h0C op_a=AND, mask_b=6'h30 op_b=OR, op_out=AND; sweep all 64 pi -> po0=pi0&pi1, po1=pi0|pi1, po4=pi2&pi3&(pi4|pi5) every vector.
REQ-038 Stream 8 vectors, out_ready low cycles 3-6 -> in_ready falls once both stages full, po stable while stalled, 8 outputs in order, txn_cnt=8.
REQ-039 cfg_we and input handshake same edge -> that vector uses old config, next vector new config.
REQ-040 sig_clr coincident with output handshake -> sig=0, txn_cnt=0; next handshake sig=zero-extended po.
REQ-041 rst asserted with 2 vectors in flight -> out_valid=0 next cycle, no stale output ever appears.

Source files
------------

// File: rtl/logic_eval_pipe.sv
// Configurable two-term AND/OR evaluator per output, followed by a DEPTH-stage
// bubble-collapsing pipeline and a shift/XOR signature over delivered vectors.
module logic_eval_pipe #(
   parameter int          NPI   = 6,
   parameter int          NPO   = 6,
   parameter int          DEPTH = 2,
   parameter int          SIG_W = 16,
   parameter logic [31:0] POLY  = 32'h0000_1021,
   localparam int         IDX_W = (NPO > 1) ? $clog2(NPO) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [NPI-1:0]   cfg_mask_a,
   input  logic [NPI-1:0]   cfg_mask_b,
   input  logic [2:0]       cfg_op,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [NPI-1:0]   pi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [NPO-1:0]   po,
   output logic [SIG_W-1:0] sig,
   input  logic             sig_clr,
   output logic [15:0]      txn_cnt
);

   logic [NPI-1:0]   mask_a_q [NPO];
   logic [NPI-1:0]   mask_a_d [NPO];
   logic [NPI-1:0]   mask_b_q [NPO];
   logic [NPI-1:0]   mask_b_d [NPO];
   logic [2:0]       op_q     [NPO];
   logic [2:0]       op_d     [NPO];

   logic [DEPTH-1:0] vld_q, vld_d;
   logic [NPO-1:0]   dat_q [DEPTH];
   logic [NPO-1:0]   dat_d [DEPTH];
   logic [DEPTH-1:0] load;
   logic             load_acc;

   logic [SIG_W-1:0] sig_q, sig_d;
   logic [15:0]      cnt_q, cnt_d;

   logic [NPO-1:0]   term_a, term_b, eval_po;
   logic             in_fire, out_fire;

   // NOTE: always_comb uses blocking '=' with every output defaulted first, so
   // no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      for (int k = 0; k < NPO; k++) begin
         mask_a_d[k] = mask_a_q[k];
         mask_b_d[k] = mask_b_q[k];
         op_d[k]     = op_q[k];
         // Indices at or beyond NPO match no entry and are dropped.
         if (cfg_we && (cfg_idx == IDX_W'(k))) begin
            mask_a_d[k] = cfg_mask_a;
            mask_b_d[k] = cfg_mask_b;
            op_d[k]     = cfg_op;
         end
      end
   end

   // Empty mask: AND-reduction yields 1, OR-reduction yields 0.
   always_comb begin
      term_a  = '0;
      term_b  = '0;
      eval_po = '0;
      for (int k = 0; k < NPO; k++) begin
         term_a[k]  = op_q[k][0] ? |(pi & mask_a_q[k]) : &(pi | ~mask_a_q[k]);
         term_b[k]  = op_q[k][1] ? |(pi & mask_b_q[k]) : &(pi | ~mask_b_q[k]);
         eval_po[k] = op_q[k][2] ? (term_a[k] | term_b[k]) : (term_a[k] & term_b[k]);
      end
   end

   assign out_fire = vld_q[DEPTH-1] & out_ready;

   // A stage may load if it or any stage downstream of it frees a slot this cycle.
   always_comb begin
      load           = '0;
      load_acc       = out_fire | ~vld_q[DEPTH-1];
      load[DEPTH-1]  = load_acc;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         load_acc = load_acc | ~vld_q[i];
         load[i]  = load_acc;
      end
   end

   assign in_ready = load[0] & ~rst;
   assign in_fire  = in_valid & in_ready;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (load[0]) begin
         vld_d[0] = in_fire;
         if (in_fire) dat_d[0] = eval_po;
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (load[i]) begin
            vld_d[i] = vld_q[i-1];
            if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
         end
      end
   end

   always_comb begin
      sig_d = sig_q;
      cnt_d = cnt_q;
      if (sig_clr) begin
         sig_d = '0;
         cnt_d = '0;
      end else if (out_fire) begin
         sig_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY[SIG_W-1:0] : '0)
               ^ SIG_W'(dat_q[DEPTH-1]);
         cnt_d = cnt_q + 16'd1;
      end
   end

   // NOTE: the config table is reset like any other state because an
   // unconfigured output must evaluate to a known 1 straight out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         sig_q <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
         for (int k = 0; k < NPO; k++) begin
            mask_a_q[k] <= '0;
            mask_b_q[k] <= '0;
            op_q[k]     <= '0;
         end
      end else begin
         vld_q    <= vld_d;
         dat_q    <= dat_d;
         sig_q    <= sig_d;
         cnt_q    <= cnt_d;
         mask_a_q <= mask_a_d;
         mask_b_q <= mask_b_d;
         op_q     <= op_d;
      end
   end

   assign out_valid = vld_q[DEPTH-1];
   assign po        = dat_q[DEPTH-1];
   assign sig       = sig_q;
   assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_logic_eval_pipe.sv
// Directed bench for logic_eval_pipe (NPI=6, NPO=6, DEPTH=2, SIG_W=16):
// reset, config/eval sweep, back-pressure, config timing, sig_clr and mid-flight reset.
module tb_logic_eval_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_we;
   logic [2:0]  cfg_idx;
   logic [5:0]  cfg_mask_a, cfg_mask_b;
   logic [2:0]  cfg_op;
   logic        in_valid, in_ready;
   logic [5:0]  pi;
   logic        out_valid, out_ready;
   logic [5:0]  po;
   logic [15:0] sig;
   logic        sig_clr;
   logic [15:0] txn_cnt;

   int n_checks = 0;
   int n_err    = 0;

   logic_eval_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_mask_a (cfg_mask_a),
      .cfg_mask_b (cfg_mask_b),
      .cfg_op     (cfg_op),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .pi         (pi),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .po         (po),
      .sig        (sig),
      .sig_clr    (sig_clr),
      .txn_cnt    (txn_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg(input logic [2:0] idx, input logic [5:0] ma, input logic [5:0] mb,
                      input logic [2:0] op);
      cfg_we     = 1'b1;
      cfg_idx    = idx;
      cfg_mask_a = ma;
      cfg_mask_b = mb;
      cfg_op     = op;
      tick();
      cfg_we     = 1'b0;
   endtask

   // Outputs under the sweep configuration: po0=p0&p1, po1=p0|p1,
   // po4=p2&p3&(p4|p5), unconfigured outputs stay 1.
   function automatic logic [5:0] exp_po(input logic [5:0] p);
      return {1'b1, p[2] & p[3] & (p[4] | p[5]), 1'b1, 1'b1, p[0] | p[1], p[0] & p[1]};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] vec [8];
      logic [5:0] held_po;
      logic [5:0] pv;
      logic       stall_prev, in_take, out_take;
      int         sent, recv;

      vec = '{6'h00, 6'h3F, 6'h0D, 6'h32, 6'h1E, 6'h21, 6'h2C, 6'h17};

      rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_mask_a = '0; cfg_mask_b = '0;
      cfg_op = '0; in_valid = 1'b0; pi = '0; out_ready = 1'b0; sig_clr = 1'b0;

      // Reset state
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_po", po, 0);
      check("rst_sig", sig, 0);
      check("rst_txn", txn_cnt, 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // Default config: every output is 1; two vectors to exercise the shift
      out_ready = 1'b1;
      in_valid  = 1'b1;
      pi        = 6'h00;
      tick();
      check("lat_not_yet", out_valid, 0);
      tick();
      in_valid = 1'b0;
      check("dflt_valid", out_valid, 1);
      check("dflt_po", po, 6'h3F);
      tick();
      check("dflt_sig1", sig, 16'h003F);
      check("dflt_txn1", txn_cnt, 1);
      tick();
      check("dflt_sig2", sig, 16'h0041);
      check("dflt_txn2", txn_cnt, 2);
      check("dflt_drained", out_valid, 0);

      sig_clr = 1'b1;
      tick();
      sig_clr = 1'b0;
      check("clr_sig", sig, 0);
      check("clr_txn", txn_cnt, 0);

      // Config then full 64-vector sweep; writes to idx 6 and 7 must be dropped
      cfg(3'd0, 6'h03, 6'h00, 3'b000);
      cfg(3'd1, 6'h03, 6'h00, 3'b001);
      cfg(3'd4, 6'h0C, 6'h30, 3'b010);
      cfg(3'd6, 6'h3F, 6'h3F, 3'b111);
      cfg(3'd7, 6'h15, 6'h2A, 3'b101);
      for (int i = 0; i <= 64; i++) begin
         in_valid = (i < 64);
         pi       = 6'(i);
         tick();
         if (i >= 1) begin
            pv = 6'(i - 1);
            check($sformatf("sweep_po_%0d", i - 1), po, exp_po(pv));
         end
      end
      in_valid = 1'b0;
      tick();
      check("sweep_txn", txn_cnt, 64);
      check("sweep_drained", out_valid, 0);

      // Back-pressure: out_ready low in cycles 3..6
      sig_clr = 1'b1;
      tick();
      sig_clr    = 1'b0;
      sent       = 0;
      recv       = 0;
      stall_prev = 1'b0;
      held_po    = '0;
      for (int c = 0; c < 40 && recv < 8; c++) begin
         out_ready = !(c >= 3 && c <= 6);
         in_valid  = (sent < 8);
         pi        = (sent < 8) ? vec[sent] : 6'h00;
         #1;
         if (c == 3) check("bp_in_ready_low", in_ready, 0);
         if (c == 7) check("bp_in_ready_back", in_ready, 1);
         if (stall_prev) check($sformatf("bp_po_hold_c%0d", c), po, held_po);
         in_take  = in_valid & in_ready;
         out_take = out_valid & out_ready;
         if (out_take) begin
            check($sformatf("bp_order_%0d", recv), po, exp_po(vec[recv]));
            recv++;
         end
         stall_prev = out_valid & ~out_ready;
         held_po    = po;
         tick();
         if (in_take) sent++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_recv", recv, 8);
      check("bp_txn", txn_cnt, 8);
      check("bp_drained", out_valid, 0);

      // Config write on the same edge as an accept: that vector sees old config
      cfg_we = 1'b1; cfg_idx = 3'd0; cfg_mask_a = 6'h03; cfg_mask_b = 6'h00; cfg_op = 3'b001;
      in_valid = 1'b1;
      pi       = 6'h01;
      tick();
      cfg_we = 1'b0;
      tick();
      in_valid = 1'b0;
      check("cfgt_old_valid", out_valid, 1);
      check("cfgt_old_po", po, 6'h2E);
      tick();
      check("cfgt_new_po", po, 6'h2F);
      tick();

      // sig_clr coincident with an output handshake
      in_valid = 1'b1;
      pi       = 6'h00;
      tick();
      in_valid = 1'b0;
      tick();
      check("sclr_po", po, 6'h2C);
      sig_clr = 1'b1;
      tick();
      sig_clr = 1'b0;
      check("sclr_sig", sig, 0);
      check("sclr_txn", txn_cnt, 0);
      check("sclr_hs_done", out_valid, 0);
      in_valid = 1'b1;
      pi       = 6'h3F;
      tick();
      in_valid = 1'b0;
      tick();
      check("sclr_next_po", po, 6'h3F);
      tick();
      check("sclr_next_sig", sig, 16'h003F);
      check("sclr_next_txn", txn_cnt, 1);

      // Reset with two vectors in flight; cfg_we and sig_clr in the same cycle lose
      out_ready = 1'b0;
      in_valid  = 1'b1;
      pi        = 6'h01;
      tick();
      pi = 6'h3F;
      tick();
      in_valid = 1'b0;
      check("mid_full", out_valid, 1);
      rst = 1'b1;
      cfg_we = 1'b1; cfg_idx = 3'd0; cfg_mask_a = 6'h3F; cfg_mask_b = 6'h00; cfg_op = 3'b001;
      sig_clr = 1'b1;
      tick();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_po", po, 0);
      check("mid_rst_in_ready", in_ready, 0);
      check("mid_rst_sig", sig, 0);
      check("mid_rst_txn", txn_cnt, 0);
      rst = 1'b0; cfg_we = 1'b0; sig_clr = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("mid_no_stale_%0d", i), out_valid, 0);
      end
      in_valid = 1'b1;
      pi       = 6'h00;
      tick();
      in_valid = 1'b0;
      tick();
      check("mid_cfg_cleared_po", po, 6'h3F);
      tick();
      check("mid_after_sig", sig, 16'h003F);
      check("mid_after_txn", txn_cnt, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
